spi_slave_param: RTL

// - Parametrised SPI slave front-end for the dual-port RAM path; next generation of the fixed 10-bit SPI slave.
// - Deserialises MOSI frames of {cmd[1:0], payload[DATA_W-1:0]} into rx_data/rx_valid for the RAM.
// - Serialises RAM read data (tx_data/tx_valid) onto MISO.
// - Adds frame-abort reporting, a configurable MISO bit order and optional frame parity.

---
 rtl/spi_slave_param_if.sv | 28 ++
 rtl/spi_slave_param.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/spi_slave_param_if.sv
// Bus interface for spi_slave_param: SPI pins plus the RAM-side rx/tx handshake.
// The slave modport is the DUT view; master is the driver/RAM view.
interface spi_slave_param_if #(
  parameter int DATA_W = 8
);
  localparam int FRAME_W = DATA_W + 2;

  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;
  logic               busy;
  logic               frame_abort;
  logic               parity_err;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid, busy, frame_abort, parity_err
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid, busy, frame_abort, parity_err
  );
endinterface

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: deserialises {cmd, payload} frames for the RAM and serialises read data.
// Optional even-parity frame bit is enabled by defining SPI_PARITY_EN.
module spi_slave_param #(
  parameter int DATA_W       = 8,
  parameter int TX_LSB_FIRST = 0
) (
  input  logic            clk,
  input  logic            rst,
  spi_slave_param_if.slave s
);
  localparam int FRAME_W = DATA_W + 2;
`ifdef SPI_PARITY_EN
  localparam int FRAME_LEN = FRAME_W + 1;
`else
  localparam int FRAME_LEN = FRAME_W;
`endif
  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam int TXC_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [TXC_W-1:0] TX_BITS  = TXC_W'(DATA_W);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t               state, state_next;
  logic [FRAME_LEN-1:0] shifter;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 frame_done;   // frame length reached and already reported this SS_n window
  logic                 rx_ok;        // current frame delivered with rx_valid
  logic                 rd_addr_done;
  logic [DATA_W-1:0]    tx_sreg;
  logic [TXC_W-1:0]     tx_left;
  logic                 tx_taken;

  logic               miso_q, rx_valid_q, frame_abort_q, parity_err_q;
  logic [FRAME_W-1:0] rx_data_q;

  logic               frame_full, shift_en, complete, abort_evt, parity_ok;
  logic [FRAME_W-1:0] rx_frame;
  logic               tx_bit;
  logic [DATA_W-1:0]  tx_shifted;

  assign frame_full = (bit_cnt == CNT_FULL);

`ifdef SPI_PARITY_EN
  assign parity_ok = ~^shifter;
  assign rx_frame  = shifter[FRAME_LEN-1:1];
`else
  assign parity_ok = 1'b1;
  assign rx_frame  = shifter;
`endif

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    complete   = 1'b0;
    abort_evt  = 1'b0;
    case (state)
      IDLE: if (!s.SS_n) state_next = CHK_CMD;
      CHK_CMD: begin
        if (s.SS_n) begin
          state_next = IDLE;
        end else begin
          shift_en = 1'b1;
          if (!s.MOSI)          state_next = WRITE;
          else if (rd_addr_done) state_next = READ_DATA;
          else                   state_next = READ_ADD;
        end
      end
      default: begin
        if (frame_full && !frame_done) complete  = 1'b1;
        else if (s.SS_n && !frame_full) abort_evt = 1'b1;
        else if (!s.SS_n && !frame_full) shift_en = 1'b1;
        if (s.SS_n) state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    if (TX_LSB_FIRST != 0) begin
      tx_bit     = tx_sreg[0];
      tx_shifted = tx_sreg >> 1;
    end else begin
      tx_bit     = tx_sreg[DATA_W-1];
      tx_shifted = tx_sreg << 1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      shifter       <= '0;
      bit_cnt       <= '0;
      frame_done    <= 1'b0;
      rx_ok         <= 1'b0;
      rd_addr_done  <= 1'b0;
      tx_sreg       <= '0;
      tx_left       <= '0;
      tx_taken      <= 1'b0;
      miso_q        <= 1'b0;
      rx_valid_q    <= 1'b0;
      frame_abort_q <= 1'b0;
      parity_err_q  <= 1'b0;
      rx_data_q     <= '0;
    end else begin
      state         <= state_next;
      rx_valid_q    <= 1'b0;
      frame_abort_q <= 1'b0;
      parity_err_q  <= 1'b0;

      if (shift_en) begin
        shifter <= {shifter[FRAME_LEN-2:0], s.MOSI};
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (complete) begin
        frame_done <= 1'b1;
        if (parity_ok) begin
          rx_data_q  <= rx_frame;
          rx_valid_q <= 1'b1;
          rx_ok      <= 1'b1;
          if (state == READ_ADD)       rd_addr_done <= 1'b1;
          else if (state == READ_DATA) rd_addr_done <= 1'b0;
        end else begin
          parity_err_q <= 1'b1;
        end
      end

      if (abort_evt) frame_abort_q <= 1'b1;

      // Leaving the SS_n window drops any partial frame.
      if (state_next == IDLE) begin
        shifter    <= '0;
        bit_cnt    <= '0;
        frame_done <= 1'b0;
        rx_ok      <= 1'b0;
      end

      if (s.SS_n) begin
        miso_q   <= 1'b0;
        tx_left  <= '0;
        tx_taken <= 1'b0;
      end else if (tx_left != '0) begin
        miso_q  <= tx_bit;
        tx_sreg <= tx_shifted;
        tx_left <= tx_left - 1'b1;
      end else begin
        miso_q <= 1'b0;
        // One read return per READ_DATA frame, never in the rx_valid cycle itself.
        if (state == READ_DATA && rx_ok && !rx_valid_q && !tx_taken && s.tx_valid) begin
          tx_sreg  <= s.tx_data;
          tx_left  <= TX_BITS;
          tx_taken <= 1'b1;
        end
      end
    end
  end

  assign s.MISO        = miso_q;
  assign s.rx_data     = rx_data_q;
  assign s.rx_valid    = rx_valid_q;
  assign s.frame_abort = frame_abort_q;
  assign s.parity_err  = parity_err_q;
  assign s.busy        = (state != IDLE);

endmodule
